instr_decode_queue: RTL
=======================

Name: instr_decode_queue

Overview:
Buffered, parametrised successor to the combinational instruction field splitter. It accepts 32-bit MIPS instructions with their PC over a valid/ready handshake and holds them in a DEPTH-entry FIFO. Each instruction is decoded into registered fields: class, sign- or zero-extended immediate, and jump target. The block sits between fetch and register-read, decoupling fetch from downstream stalls.

Parameters:
DEPTH, 4, FIFO entries; power of 2, at least 2.
DATA_WIDTH, 32, width of the extended immediate; at least 32.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
flush  in  1  discards all queued and output-held instructions.
in_valid  in  1  instruction/pc presented.
in_ready  out  1  block can accept this cycle.
instr_in  in  32  raw instruction.
pc_in  in  32  address of instr_in.
out_valid  out  1  decoded fields valid.
out_ready  in  1  consumer accepts decoded fields.
op  out  6  instr[31:26].
rs  out  5  instr[25:21].
rt  out  5  instr[20:16].
rd  out  5  instr[15:11].
shamt  out  5  instr[10:6].
funct  out  6  instr[5:0].
imm_ext  out  DATA_WIDTH  extended instr[15:0].
jump_target  out  32  {pc+4[31:28], instr[25:0], 2'b00}.
instr_class  out  2  0=R, 1=I, 2=J, 3=illegal.
pc_out  out  32  pc of the decoded instruction.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: all outputs are 0, FIFO count is 0, in_ready=1 (combinational from count).
- Accept: when in_valid and in_ready, {instr_in, pc_in} is written at the FIFO tail.
- in_ready = (count < DEPTH); it does not depend on out_ready.
- Transfer: when FIFO is non-empty and (!out_valid or out_ready), the head is popped, decoded and registered into the output stage. out_valid is 1 after that edge.
- Consume without refill: if out_valid and out_ready and the FIFO is empty, out_valid goes to 0.
- Latency: an accepted instruction appears at the output 2 edges later when the path is empty. Sustained throughput is 1 per cycle.
- Stall: while out_valid and !out_ready, all outputs hold stable. Capacity is DEPTH+1 instructions (FIFO plus output register).
- Simultaneous push and pop in one cycle: allowed, count unchanged. Pointers wrap modulo DEPTH.
- Class decode:
  - op 0x00: R.
  - op 0x02 (j), 0x03 (jal): J.
  - every other op: I, subject to the Optional Feature.
- Immediate extension: zero-extended for op 0x0C/0x0D/0x0E (andi/ori/xori). Sign-extended for all other ops.
- All fields are decoded and driven regardless of class; the consumer ignores the irrelevant ones.
- Flush: overrides all other activity that edge. Count, pointers and out_valid go to 0; an in_valid presented that cycle is dropped. Field outputs keep their last values.
- Reset mid-operation: same effect as flush, plus all outputs go to 0.

Optional Feature:
Macro DECODE_ILLEGAL_EN.
- Defined: op outside {0x00,0x02,0x03,0x04,0x05,0x08,0x0A,0x0C,0x0D,0x0E,0x0F,0x23,0x2B} gives instr_class=3. The instruction still flows through normally.
- Undefined: class 3 is never produced; unknown ops decode as I.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW);
  - class codes CLASS_R/I/J/ILL;
  - the zero-extend opcode list.
- One sub-module, instr_fifo: parametrised DEPTH, 64-bit entries, push/pop/full/empty/count.
- Decode logic and the output register stay in the top.

Test Plan:
- Field decode: push 0x00221820, pc 0x0, out_ready=1 -> 2 edges later out_valid=1, class=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20.
- Extension: push 0x2132D8A7 (addi) then 0x3532D8A7 (ori) -> imm_ext 0xFFFFD8A7 then 0x0000D8A7; rs=9, rt=18 for both.
- Jump: push 0x0AA8E52B, pc 0x40000000 -> class=2, jump_target=0x4AA394AC.
- Backpressure, DEPTH=4: out_ready=0, attempt 6 pushes -> exactly 5 accepted; in_ready=0 after the 5th. Raise out_ready -> all 5 emerge in push order, one per cycle.
- Flush: 3 queued, then assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1; no stale output later. Reset mid-stream produces the same result with fields at 0.
- With DECODE_ILLEGAL_EN: push op 0x3F -> class=3. Without it -> class=1.

Source files
------------

// File: rtl/instr_decode_queue_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the instruction decode queue:
//   - MIPS opcode constants used by class and immediate decode
//   - instruction class codes (R / I / J / illegal)
//   - the list of opcodes whose immediate is zero-extended
//   - the registered field bundle carried by the output stage
// No ports (package).
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = INSTR_W + PC_W;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        CLASS_R   = 2'd0,
        CLASS_I   = 2'd1,
        CLASS_J   = 2'd2,
        CLASS_ILL = 2'd3
    } instr_class_e;

    // Logical immediates are zero-extended; everything else sign-extends.
    localparam int NUM_ZEXT_OPS = 3;
    localparam logic [5:0] ZEXT_OPS [NUM_ZEXT_OPS] = '{OP_ANDI, OP_ORI, OP_XORI};

    function automatic logic is_zero_ext(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_ZEXT_OPS; i++) begin
            if (op == ZEXT_OPS[i]) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    function automatic logic is_known_op(input logic [5:0] op);
        logic known;
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: known = 1'b1;
            default:                                        known = 1'b0;
        endcase
        return known;
    endfunction

    // Width-independent part of the output stage (the immediate is kept
    // separately because its width is a module parameter).
    typedef struct packed {
        logic [5:0]   op;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [4:0]   shamt;
        logic [5:0]   funct;
        logic [31:0]  jump_target;
        instr_class_e iclass;
        logic [31:0]  pc;
    } fields_t;

endpackage

// File: rtl/instr_decode_queue_if.sv
// -----------------------------------------------------------------------------
// instr_decode_queue_if
// Groups the fetch-side push handshake, the flush strobe and the decoded
// output handshake of instr_decode_queue.
//   master : producer/consumer side (drives flush, in_valid, instr_in, pc_in,
//            out_ready; observes in_ready and all decoded outputs)
//   slave  : the decode queue itself
// Parameter DATA_WIDTH sets the width of imm_ext.
// -----------------------------------------------------------------------------
interface instr_decode_queue_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr_in;
    logic [31:0]           pc_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [5:0]            op;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic [5:0]            funct;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [31:0]           jump_target;
    logic [1:0]            instr_class;
    logic [31:0]           pc_out;

    modport master (
        output flush, in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, op, rs, rt, rd, shamt, funct,
               imm_ext, jump_target, instr_class, pc_out
    );

    modport slave (
        input  flush, in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, op, rs, rt, rd, shamt, funct,
               imm_ext, jump_target, instr_class, pc_out
    );
endinterface

// File: rtl/instr_decode_queue_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// DEPTH-entry synchronous FIFO holding {instr, pc} pairs for the decode queue.
// DEPTH must be a power of 2 (>= 2) so the pointers wrap by plain overflow.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           empties the FIFO, overriding push/pop that edge
//   push, wr_data   write wr_data at the tail (ignored when full)
//   pop, rd_data    rd_data is the current head; pop advances it (ignored when empty)
//   full, empty     status flags
//   count           number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it
    // has been written, so clearing it would cost flops and buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/instr_decode_queue.sv
// -----------------------------------------------------------------------------
// instr_decode_queue
// Buffered MIPS instruction decoder between fetch and register-read.
// Instructions and their PCs are pushed into a DEPTH-entry FIFO; the head is
// decoded and captured in a registered output stage, giving DEPTH+1 total
// capacity and a 2-edge empty-path latency at one instruction per cycle.
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high; clears queue and zeroes all outputs
//   bus    instr_decode_queue_if.slave:
//            flush, in_valid/in_ready, instr_in, pc_in     (push side)
//            out_valid/out_ready, op, rs, rt, rd, shamt,
//            funct, imm_ext, jump_target, instr_class,
//            pc_out                                         (decoded side)
// Parameters: DEPTH (power of 2, >= 2), DATA_WIDTH (imm_ext width, >= 32).
// Build option: define DECODE_ILLEGAL_EN to classify unlisted opcodes as
// illegal (class 3); otherwise they decode as I-type.
// -----------------------------------------------------------------------------
module instr_decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    instr_decode_queue_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // FIFO interface
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               push;
    logic               pop;

    // Head-of-queue decode
    logic [INSTR_W-1:0]    head_instr;
    logic [PC_W-1:0]       head_pc;
    logic [3:0]            pc4_hi;
    fields_t               dec_fields;
    logic [DATA_WIDTH-1:0] dec_imm;

    // Output stage
    logic                  out_valid_q, out_valid_d;
    fields_t               fields_q, fields_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;

    assign bus.in_ready = (fifo_count < DEPTH_CNT);

    assign push = bus.in_valid && !fifo_full && !bus.flush;
    // The output register is refilled whenever it is empty or being drained.
    assign pop  = !fifo_empty && (!out_valid_q || bus.out_ready) && !bus.flush;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.flush),
        .push    (push),
        .wr_data ({bus.instr_in, bus.pc_in}),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_instr = fifo_rd_data[ENTRY_W-1:PC_W];
    assign head_pc    = fifo_rd_data[PC_W-1:0];

    // (pc+4)[31:28] without a full 32-bit adder: the +4 carries into bit 28
    // only when pc[27:2] is all ones.
    assign pc4_hi = head_pc[31:28] + {3'b000, &head_pc[27:2]};

    always_comb begin
        dec_fields             = '0;
        dec_fields.op          = head_instr[31:26];
        dec_fields.rs          = head_instr[25:21];
        dec_fields.rt          = head_instr[20:16];
        dec_fields.rd          = head_instr[15:11];
        dec_fields.shamt       = head_instr[10:6];
        dec_fields.funct       = head_instr[5:0];
        dec_fields.jump_target = {pc4_hi, head_instr[25:0], 2'b00};
        dec_fields.pc          = head_pc;

        if (dec_fields.op == OP_RTYPE) begin
            dec_fields.iclass = CLASS_R;
        end else if ((dec_fields.op == OP_J) || (dec_fields.op == OP_JAL)) begin
            dec_fields.iclass = CLASS_J;
        end else begin
`ifdef DECODE_ILLEGAL_EN
            dec_fields.iclass = is_known_op(dec_fields.op) ? CLASS_I : CLASS_ILL;
`else
            dec_fields.iclass = CLASS_I;
`endif
        end

        if (is_zero_ext(dec_fields.op)) begin
            dec_imm = {{(DATA_WIDTH-16){1'b0}}, head_instr[15:0]};
        end else begin
            dec_imm = {{(DATA_WIDTH-16){head_instr[15]}}, head_instr[15:0]};
        end
    end

    // Output stage next state: flush only drops valid, fields keep their
    // last values; a pop loads new fields; a drain with no refill clears valid.
    always_comb begin
        out_valid_d = out_valid_q;
        fields_d    = fields_q;
        imm_d       = imm_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (pop) begin
            out_valid_d = 1'b1;
            fields_d    = dec_fields;
            imm_d       = dec_imm;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            fields_q    <= '0;
            imm_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            fields_q    <= fields_d;
            imm_q       <= imm_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.op          = fields_q.op;
    assign bus.rs          = fields_q.rs;
    assign bus.rt          = fields_q.rt;
    assign bus.rd          = fields_q.rd;
    assign bus.shamt       = fields_q.shamt;
    assign bus.funct       = fields_q.funct;
    assign bus.imm_ext     = imm_q;
    assign bus.jump_target = fields_q.jump_target;
    assign bus.instr_class = fields_q.iclass;
    assign bus.pc_out      = fields_q.pc;

endmodule
